// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic c_P0 = 1'b0;
    localparam logic c_P1 = 1'b1;

    localparam int c_DEF_ADDR_W = 11;
    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_RD_LAT = 2;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester ports and memory pins of the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DATA_W = c_DEF_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side
    modport master (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_done, p0_rdata,
        output p1_gnt, p1_done, p1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, busy
    );

    // Requesters and memory side
    modport slave (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_done, p0_rdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational 2-way picker, round-robin or port-0 fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       win,
    output logic       valid
);

    always_comb begin
        valid = |req;
        win   = c_P0;
        if (req == 2'b10) begin
            win = c_P1;
        end else if (req == 2'b11) begin
            // On a tie the port not granted last wins, unless port 0 is pinned
            win = fixed_prio ? c_P0 : ~last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between two req/gnt/done requesters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int RD_LAT     = c_DEF_RD_LAT,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  arb_bus
);

    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_port;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_win;
    logic              w_valid;
    logic              w_wait_end;
    logic              w_capture;
    logic              w_acc;
    logic              w_addr_phase;

    rr_arb2 u_pick (
        .req        ({arb_bus.p1_req, arb_bus.p0_req}),
        .last       (r_last),
        .fixed_prio (FIXED_PRIO != 0),
        .win        (w_win),
        .valid      (w_valid)
    );

    // Counter holds the remaining read cycles; the value 1 marks the sampling cycle
    assign w_wait_end = (r_cnt == CNT_W'(1));
    assign w_capture  = !r_we && (((r_state == S_ACC) && (RD_LAT == 1)) ||
                                  ((r_state == S_WAIT) && w_wait_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_next = S_ACC;
            S_ACC:   w_next = (r_we || (RD_LAT == 1)) ? S_RESP : S_WAIT;
            S_WAIT:  if (w_wait_end) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_port  <= c_P0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_last  <= c_P1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_port  <= w_win;
                        r_we    <= (w_win == c_P1) ? arb_bus.p1_we    : arb_bus.p0_we;
                        r_addr  <= (w_win == c_P1) ? arb_bus.p1_addr  : arb_bus.p0_addr;
                        r_wdata <= (w_win == c_P1) ? arb_bus.p1_wdata : arb_bus.p0_wdata;
                    end
                end
                S_ACC:   r_cnt  <= CNT_W'(RD_LAT - 1);
                S_WAIT:  r_cnt  <= r_cnt - CNT_W'(1);
                S_RESP:  r_last <= r_port;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_capture) begin
            if (r_port == c_P1) begin
                r_rdata1 <= arb_bus.mem_rdata;
            end else begin
                r_rdata0 <= arb_bus.mem_rdata;
            end
        end
    end

    assign w_acc        = (r_state == S_ACC);
    assign w_addr_phase = w_acc || (r_state == S_WAIT);

    assign arb_bus.p0_gnt    = w_acc && (r_port == c_P0);
    assign arb_bus.p1_gnt    = w_acc && (r_port == c_P1);
    assign arb_bus.p0_done   = (r_state == S_RESP) && (r_port == c_P0);
    assign arb_bus.p1_done   = (r_state == S_RESP) && (r_port == c_P1);
    assign arb_bus.p0_rdata  = r_rdata0;
    assign arb_bus.p1_rdata  = r_rdata1;
    assign arb_bus.mem_addr  = w_addr_phase ? r_addr : '0;
    assign arb_bus.mem_read  = (w_acc && !r_we) || (r_state == S_WAIT);
    assign arb_bus.mem_write = w_acc && r_we;
    assign arb_bus.mem_wdata = (w_acc && r_we) ? r_wdata : '0;
    assign arb_bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Random two-port traffic on four arbiter configurations, scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NCYC = 1500;

    typedef struct { int cyc; bit port; } gexp_t;
    typedef struct { int cyc; bit port; bit we; logic [15:0] rd; } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fin  = 0;

    task automatic chk(input int cfg, input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL cfg%0d %s got=%0h exp=%0h (t=%0t)", cfg, nm, got, exp, $time);
    endtask

    function automatic logic [63:0] ev(input int c, input logic [1:0] v);
        return {c[31:0], 30'd0, v};
    endfunction

    function automatic logic [1:0] oh(input bit p);
        return p ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] init_val(input int i, input int c);
        if (i == 5) return 16'h3007;
        return 16'((i * 40503 + c * 7919) ^ (i >> 3));
    endfunction

    function automatic logic [10:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return 11'h000;
            1:       return 11'h7FF;
            2:       return 11'h005;
            3, 4, 5: return 11'($urandom_range(0, 15));
            default: return 11'($urandom);
        endcase
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int LAT = (gi == 2) ? 1 : ((gi == 3) ? 4 : 2);
        localparam int FP  = (gi == 1) ? 1 : 0;

        logic        rst;
        logic [1:0]  rq;
        logic [1:0]  rwe;
        logic [10:0] raddr [2];
        logic [15:0] rwd   [2];
        logic [15:0] mem   [2048];
        logic [15:0] ref_m [2048];
        logic [15:0] hold_rd [2] = '{16'h0, 16'h0};
        int          rd_run;
        int          blo = -1;
        int          bhi = -1;
        bit          started = 1'b0;
        gexp_t       gq[$];
        dexp_t       dq[$];

        mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

        mem_port_arbiter #(
            .ADDR_W     (11),
            .DATA_W     (16),
            .RD_LAT     (LAT),
            .FIXED_PRIO (FP)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .arb_bus (bus)
        );

        assign bus.p0_req   = rq[0];
        assign bus.p1_req   = rq[1];
        assign bus.p0_we    = rwe[0];
        assign bus.p1_we    = rwe[1];
        assign bus.p0_addr  = raddr[0];
        assign bus.p1_addr  = raddr[1];
        assign bus.p0_wdata = rwd[0];
        assign bus.p1_wdata = rwd[1];

        // Memory returns real data only in the RD_LAT-th consecutive read cycle
        assign bus.mem_rdata = ((bus.mem_read === 1'b1) && (rd_run == LAT - 1)) ?
                               mem[bus.mem_addr] : ~mem[bus.mem_addr];

        initial begin : mem_model
            for (int i = 0; i < 2048; i++) mem[i] = init_val(i, gi);
            rd_run = 0;
            forever begin
                @(posedge clk);
                rd_run <= (bus.mem_read === 1'b1) ? rd_run + 1 : 0;
                if (bus.mem_write === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
            end
        end

        always @(negedge clk) begin : monitor
            logic [1:0] g;
            logic [1:0] d;
            gexp_t      ge;
            dexp_t      de;
            if (started) begin
                g = {bus.p1_gnt, bus.p0_gnt};
                d = {bus.p1_done, bus.p0_done};
                if (g != 2'b00) begin
                    if (gq.size() == 0) chk(gi, "gnt_unexpected", ev(cyc, g), ev(cyc, 2'b00));
                    else begin
                        ge = gq.pop_front();
                        chk(gi, "gnt", ev(cyc, g), ev(ge.cyc, oh(ge.port)));
                    end
                end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                    ge = gq.pop_front();
                    chk(gi, "gnt_missing", ev(cyc, g), ev(ge.cyc, oh(ge.port)));
                end
                if (d != 2'b00) begin
                    if (dq.size() == 0) chk(gi, "done_unexpected", ev(cyc, d), ev(cyc, 2'b00));
                    else begin
                        de = dq.pop_front();
                        chk(gi, "done", ev(cyc, d), ev(de.cyc, oh(de.port)));
                        if (!de.we) hold_rd[de.port] = de.rd;
                        chk(gi, "p0_rdata", bus.p0_rdata, hold_rd[0]);
                        chk(gi, "p1_rdata", bus.p1_rdata, hold_rd[1]);
                    end
                end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                    de = dq.pop_front();
                    chk(gi, "done_missing", ev(cyc, d), ev(de.cyc, oh(de.port)));
                end
                chk(gi, "busy", bus.busy, (cyc >= blo) && (cyc <= bhi));
                chk(gi, "strobe_both", bus.mem_read & bus.mem_write, 0);
                chk(gi, "strobe_idle", (bus.mem_read | bus.mem_write) & !((cyc >= blo) && (cyc <= bhi)), 0);
                if (rst) hold_rd = '{16'h0, 16'h0};
            end
        end

        initial begin : driver
            bit hold [2];
            bit infl [2];
            int dn   [2];
            int idle_from;
            int last;
            int k;
            int w;
            for (int i = 0; i < 2048; i++) ref_m[i] = init_val(i, gi);
            hold = '{1'b0, 1'b0};
            infl = '{1'b0, 1'b0};
            dn   = '{0, 0};
            rst = 1'b1;
            rq  = 2'b00;
            rwe = 2'b00;
            raddr = '{11'h0, 11'h0};
            rwd   = '{16'h0, 16'h0};
            repeat (3) @(posedge clk);
            #1;
            chk(gi, "reset_ctrl", {bus.p0_gnt, bus.p0_done, bus.p1_gnt, bus.p1_done, bus.mem_read,
                                   bus.mem_write, bus.busy, bus.mem_addr, bus.mem_wdata}, 0);
            chk(gi, "reset_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
            rst       = 1'b0;
            idle_from = cyc;
            last      = 1;
            started   = 1'b1;

            for (int n = 0; n < NCYC; n++) begin
                @(posedge clk);
                #1;
                k = cyc;
                if (n > 20 && n < NCYC - 40 && k < bhi && $urandom_range(0, 29) == 0) begin
                    // Abort whatever is in flight; only events up to this cycle survive
                    rst       = 1'b1;
                    rq        = 2'b00;
                    hold      = '{1'b0, 1'b0};
                    infl      = '{1'b0, 1'b0};
                    last      = 1;
                    idle_from = k + 1;
                    if (bhi > k) bhi = k;
                    while (gq.size() != 0 && gq[gq.size()-1].cyc > k) void'(gq.pop_back());
                    while (dq.size() != 0 && dq[dq.size()-1].cyc > k) void'(dq.pop_back());
                    continue;
                end
                rst = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (infl[p] && k == dn[p] + 1) begin
                        infl[p] = 1'b0;
                        hold[p] = 1'b0;
                        rq[p]   = 1'b0;
                        if ($urandom_range(0, 1) == 1) begin
                            hold[p]  = 1'b1;
                            rq[p]    = 1'b1;
                            rwe[p]   = 1'($urandom_range(0, 1));
                            raddr[p] = pick_addr();
                            rwd[p]   = 16'($urandom);
                        end
                    end else if (infl[p]) begin
                        if (rq[p] && $urandom_range(0, 3) == 0) begin
                            rq[p]    = 1'b0;
                            rwe[p]   = 1'($urandom_range(0, 1));
                            raddr[p] = pick_addr();
                            rwd[p]   = 16'($urandom);
                        end
                    end else if (hold[p]) begin
                        rq[p] = 1'b1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        hold[p]  = 1'b1;
                        rq[p]    = 1'b1;
                        rwe[p]   = 1'($urandom_range(0, 1));
                        raddr[p] = pick_addr();
                        rwd[p]   = 16'($urandom);
                    end else begin
                        // Short pulse while the bus is taken: must never be served
                        rq[p] = (k < idle_from) && ($urandom_range(0, 3) == 0);
                    end
                end
                if (k >= idle_from && rq != 2'b00) begin
                    if (rq == 2'b11) w = (FP != 0) ? 0 : ((last == 0) ? 1 : 0);
                    else             w = rq[1] ? 1 : 0;
                    infl[w] = 1'b1;
                    dn[w]   = rwe[w] ? k + 2 : k + LAT + 1;
                    gq.push_back('{k + 1, w[0]});
                    dq.push_back('{dn[w], w[0], rwe[w], rwe[w] ? 16'h0 : ref_m[raddr[w]]});
                    if (rwe[w]) ref_m[raddr[w]] = rwd[w];
                    idle_from = dn[w] + 1;
                    blo       = k + 1;
                    bhi       = dn[w];
                    last      = w;
                end
            end

            @(posedge clk);
            #1;
            rst = 1'b0;
            rq  = 2'b00;
            for (int t = 0; t < 40 && (gq.size() + dq.size()) != 0; t++) @(posedge clk);
            chk(gi, "drain_empty", gq.size() + dq.size(), 0);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && n_fin < 4; t++) @(posedge clk);
        if (n_fin < 4) begin
            n_chk++;
            $display("FAIL timeout finished=%0d required=4", n_fin);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
